mem_access_master: RTL and testbench
====================================

# mem_access_master

Initiator side of the byte-addressable memory handshake: accepts one load/store request at a time from the CPU control unit and drives the memory's enable, read/write, byte, address and write-data lines. It waits for the memory's MOC (memory operation complete, low while busy) acknowledge, then returns read data. It sits between the control unit and the instruction/data memory. It converts the memory's asynchronous MOC handshake into a clean single-clock valid/ready interface.

## Interface
- SYNC_STAGES, 2, flip-flop stages synchronising mem_moc (min 2)
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_LO+WAIT_HI before abort (used only with MEM_TIMEOUT_EN)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present; accepted on a clk edge where req_valid & req_ready
- req_rw  in  1  0 = read, 1 = write
- req_byte  in  1  0 = 32-bit word, 1 = single byte
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte store uses [7:0]
- req_ready  out  1  idle and synchronized MOC high
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read data, valid with resp_valid, held until next completion
- resp_err  out  1  timeout abort flag, valid with resp_valid
- mem_enable  out  1  memory enable; memory starts on its rising edge
- mem_rw  out  1  registered copy of req_rw
- mem_byte  out  1  registered copy of req_byte
- mem_address  out  32  registered copy of req_addr
- mem_data_in  out  32  registered copy of req_wdata
- mem_data_out  in  32  memory read data
- mem_moc  in  1  memory handshake; idles 1, 0 while busy, returns to 1 when done

## Operation
- States: IDLE, WAIT_LO, WAIT_HI, DONE. moc_s = mem_moc after SYNC_STAGES flops.
- IDLE: req_ready = moc_s. On accept: latch rw/byte/addr/wdata into mem_* regs, mem_enable<=1, go WAIT_LO.
- WAIT_LO: mem_enable held 1; wait for moc_s==0, then go WAIT_HI.
- WAIT_HI: wait for moc_s==1; on that edge capture resp_rdata (word: mem_data_out; byte: {24'd0, mem_data_out[7:0]}; write: resp_rdata unchanged), mem_enable<=0, go DONE.
- DONE: resp_valid=1, resp_err=0 for exactly one cycle, then IDLE.
- mem_rw/mem_byte/mem_address/mem_data_in stable from mem_enable rise until the cycle after mem_enable falls; they change only on accept.
- req_* inputs ignored outside IDLE; no queueing.
- Reset values: state IDLE, mem_enable 0, mem_rw 0, mem_byte 0, mem_address 0, mem_data_in 0, resp_valid 0, resp_rdata 0, resp_err 0, sync flops 1 (MOC idle), timeout counter 0.
- Reset mid-operation: all of the above forced on the reset edge, in-flight access abandoned, no resp_valid. If memory is still busy, moc_s==0 keeps req_ready low until MOC returns high. No new access overlaps the orphaned one.

## Timing
- Accept at edge N; mem_enable high from N+1.
- Minimum latency accept to resp_valid = SYNC_STAGES (MOC fall) + SYNC_STAGES (MOC rise) + 2 cycles, plus memory busy time.
- mem_enable low ≥2 cycles between accesses (DONE + IDLE accept cycle).
- Requirement on memory: MOC low width ≥ SYNC_STAGES+1 clk periods; mem_data_out stable from MOC fall until mem_enable falls.
- resp_valid is never asserted in consecutive cycles.

## Configuration
- MEM_TIMEOUT_EN defined: counter cleared on accept, increments each cycle in WAIT_LO/WAIT_HI. On reaching TIMEOUT_CYCLES: mem_enable<=0, go DONE with resp_err=1 and resp_rdata=0.
- MEM_TIMEOUT_EN undefined: no counter; the master waits indefinitely in WAIT_LO/WAIT_HI; resp_err tied 0; TIMEOUT_CYCLES unused.

## Test plan
- Word read addr 0x0, memory model returns 0x8C010004, MOC low 10 cycles -> one resp_valid, resp_rdata=0x8C010004, resp_err=0, mem_enable high throughout the wait.
- Byte read addr 0x5, mem_data_out=0xDEADBEA7 -> resp_rdata=0x000000A7.
- Word write 0x12345678 to addr 0x10, then word read 0x10 -> model holds bytes 12,34,56,78 at 0x10..0x13; read returns 0x12345678; mem_data_in stable for the whole write.
- Back-to-back: req_valid held high for two reads -> mem_enable low ≥2 cycles between them; second accepted only after DONE; exactly two resp_valid pulses.
- Reset asserted in WAIT_HI while model holds MOC low 20 more cycles -> mem_enable 0 next cycle, no resp_valid, req_ready stays 0 until moc_s returns 1.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never drops MOC -> resp_valid with resp_err=1, resp_rdata=0, 16 cycles after mem_enable rise; without the macro, no response after 1000 cycles.

Source files
------------

// File: rtl/mem_access_master.sv
// mem_access_master: CPU-side initiator for the byte-addressable memory with MOC (operation complete) handshake.
// Latency: accept to resp_valid = memory busy time + SYNC_STAGES (fall) + SYNC_STAGES (rise) + 2 cycles minimum.
// Backpressure: one access in flight; req_ready low outside IDLE and while the synchronised MOC is low.
// Optional feature macro: MEM_TIMEOUT_EN (abort a stuck access after TIMEOUT_CYCLES in WAIT_LO/WAIT_HI).
module mem_access_master #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic        i_req_rw,
    input  logic        i_req_byte,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_enable,
    output logic        o_mem_rw,
    output logic        o_mem_byte,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_data_in,
    input  logic [31:0] i_mem_data_out,
    input  logic        i_mem_moc
);

    typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, DONE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_moc_sync;
    logic [SYNC_STAGES-1:0] r_sync_fill;
    logic                   r_mem_enable;
    logic                   r_mem_rw;
    logic                   r_mem_byte;
    logic [31:0]            r_mem_address;
    logic [31:0]            r_mem_data_in;
    logic                   r_resp_valid;
    logic [31:0]            r_resp_rdata;
    logic                   r_resp_err;

    logic                   w_moc_s;
    logic                   w_sync_primed;
    logic                   w_accept;
    logic                   w_tmo_hit;

    assign w_moc_s       = r_moc_sync[SYNC_STAGES-1];
    // The sync chain resets to the idle level, so it only reflects the real MOC
    // once SYNC_STAGES fresh samples have shifted in; until then a memory that is
    // still busy from an abandoned access could otherwise look idle.
    assign w_sync_primed = r_sync_fill[SYNC_STAGES-1];
    assign o_req_ready   = (r_state == IDLE) && w_moc_s && w_sync_primed;
    assign w_accept      = i_req_valid && o_req_ready;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    // Abort on the edge where the wait count reaches TIMEOUT_CYCLES.
    assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Wait-cycle counter: cleared on accept, counts every WAIT_LO/WAIT_HI cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_LO || r_state == WAIT_HI) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
    assign w_tmo_hit    = 1'b0;
`endif

    // Synchronise the asynchronous MOC handshake and track when the chain is primed.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_moc_sync  <= '1;
            r_sync_fill <= '0;
        end else begin
            r_moc_sync  <= {r_moc_sync[SYNC_STAGES-2:0], i_mem_moc};
            r_sync_fill <= {r_sync_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Access sequencer: latch request, wait for MOC low then high, issue one response pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_mem_enable  <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_byte    <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mem_rw      <= i_req_rw;
                        r_mem_byte    <= i_req_byte;
                        r_mem_address <= i_req_addr;
                        r_mem_data_in <= i_req_wdata;
                        r_mem_enable  <= 1'b1;
                        r_state       <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (w_tmo_hit) begin
                        r_mem_enable <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                        r_state      <= DONE;
                    end else if (!w_moc_s) begin
                        r_state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (w_tmo_hit) begin
                        r_mem_enable <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                        r_state      <= DONE;
                    end else if (w_moc_s) begin
                        // Writes leave the last read data in place.
                        if (!r_mem_rw) begin
                            r_resp_rdata <= r_mem_byte ? {24'd0, i_mem_data_out[7:0]} : i_mem_data_out;
                        end
                        r_mem_enable <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_state      <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_enable  = r_mem_enable;
    assign o_mem_rw      = r_mem_rw;
    assign o_mem_byte    = r_mem_byte;
    assign o_mem_address = r_mem_address;
    assign o_mem_data_in = r_mem_data_in;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_rdata  = r_resp_rdata;
    assign o_resp_err    = r_resp_err;

endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: exercises mem_access_master against a byte-array memory model with a MOC handshake.
// Expected data comes from a shadow byte array updated from the issued requests (big-endian words).
// Directed cases first (word/byte read, write-read, back-to-back, reset mid-access, stuck memory), then random traffic.
module tb_mem_access_master;
    localparam int SYNC = 2;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_rw, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_enable, mem_rw, mem_byte;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_moc;

    always #5 clk = ~clk;

    mem_access_master #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .i_req_rw(req_rw), .i_req_byte(req_byte),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid),
        .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_mem_enable(mem_enable), .o_mem_rw(mem_rw), .o_mem_byte(mem_byte),
        .o_mem_address(mem_address), .o_mem_data_in(mem_data_in),
        .i_mem_data_out(mem_data_out), .i_mem_moc(mem_moc)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mdl_mem [0:255];
    logic [7:0]  gold    [0:255];
    int          mdl_busy = 5;
    bit          mdl_hang = 1'b0;
    logic [23:0] mdl_junk = 24'd0;
    bit          mdl_prev_en = 1'b0;
    int          mdl_unstable = 0;

    int n_resp = 0, n_consec = 0, gap_viol = 0, low_run = 100;
    bit mon_prev_rv = 1'b0, mon_prev_en = 1'b0;

    int          exp_resp  = 0;
    logic [31:0] exp_rdata = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gold_rd(input logic [7:0] a, input bit by);
        if (by) return {24'd0, gold[a]};
        return {gold[a], gold[a + 8'd1], gold[a + 8'd2], gold[a + 8'd3]};
    endfunction

    // Memory model: starts on the enable rise, holds MOC low for mdl_busy cycles.
    initial begin
        logic [31:0] a;
        logic        rw, by;
        logic [31:0] wd;
        mem_moc      = 1'b1;
        mem_data_out = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (mem_enable === 1'b1 && !mdl_prev_en && !mdl_hang) begin
                a = mem_address; rw = mem_rw; by = mem_byte; wd = mem_data_in;
                if (rw) begin
                    if (by) mdl_mem[a[7:0]] = wd[7:0];
                    else begin
                        mdl_mem[a[7:0]]        = wd[31:24];
                        mdl_mem[a[7:0] + 8'd1] = wd[23:16];
                        mdl_mem[a[7:0] + 8'd2] = wd[15:8];
                        mdl_mem[a[7:0] + 8'd3] = wd[7:0];
                    end
                end else begin
                    mem_data_out = by ? {mdl_junk, mdl_mem[a[7:0]]}
                                      : {mdl_mem[a[7:0]], mdl_mem[a[7:0] + 8'd1],
                                         mdl_mem[a[7:0] + 8'd2], mdl_mem[a[7:0] + 8'd3]};
                end
                mem_moc = 1'b0;
                for (int k = 0; k < mdl_busy; k++) begin
                    @(posedge clk); #1;
                    if (mem_enable === 1'b1 &&
                        (mem_address !== a || mem_data_in !== wd || mem_rw !== rw || mem_byte !== by))
                        mdl_unstable++;
                end
                mem_moc = 1'b1;
            end
            mdl_prev_en = (mem_enable === 1'b1);
        end
    end

    // Protocol monitor: response pulses, back-to-back pulses, enable-low gaps.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) n_resp++;
        if (resp_valid === 1'b1 && mon_prev_rv) n_consec++;
        mon_prev_rv = (resp_valid === 1'b1);
        if (mem_enable === 1'b1) begin
            if (!mon_prev_en && low_run < 2) gap_viol++;
            low_run = 0;
        end else begin
            low_run++;
        end
        mon_prev_en = (mem_enable === 1'b1);
    end

    // One request through the handshake; checks latency, held enable, data and pulse width.
    task automatic do_req(input bit rw, input bit by, input logic [31:0] addr,
                          input logic [31:0] wd, input int busy, input string tag,
                          output logic [31:0] rd);
        int w, lat;
        bit en_ok, got;
        mdl_busy = busy;
        w = 0;
        while (req_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_rw = rw; req_byte = by; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_rw = ~rw; req_addr = $urandom; req_wdata = $urandom;
        if (rw) begin
            if (by) gold[addr[7:0]] = wd[7:0];
            else for (int i = 0; i < 4; i++) gold[addr[7:0] + 8'(i)] = wd[31 - 8*i -: 8];
        end else begin
            exp_rdata = gold_rd(addr[7:0], by);
        end
        exp_resp++;
        lat = 0; en_ok = 1'b1; got = 1'b0;
        while (!got && lat < 300) begin
            if (resp_valid === 1'b1) got = 1'b1;
            else begin
                if (mem_enable !== 1'b1 || mem_address !== addr) en_ok = 1'b0;
                @(posedge clk); #1; lat++;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(busy + SYNC + 1));
        chk({tag, " enable_held"}, 32'(en_ok), 32'd1);
        chk({tag, " rdata"}, resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(resp_err), 32'd0);
        chk({tag, " enable_off"}, 32'(mem_enable), 32'd0);
        rd = resp_rdata;
        @(posedge clk); #1;
        chk({tag, " pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int w, lat, base;
        bit ok, acc;
        logic [31:0] rd, first_rd, e1, e2, a;
        logic [7:0] b;

        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_byte = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom); mdl_mem[i] = b; gold[i] = b;
        end
        repeat (3) @(posedge clk); #1;
        chk("rst enable", 32'(mem_enable), 32'd0);
        chk("rst rw", 32'(mem_rw), 32'd0);
        chk("rst byte", 32'(mem_byte), 32'd0);
        chk("rst addr", mem_address, 32'd0);
        chk("rst din", mem_data_in, 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst err", 32'(resp_err), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        chk("ready after reset", 32'(w), 32'(SYNC));

        // Word read at 0.
        mdl_mem[0] = 8'h8C; mdl_mem[1] = 8'h01; mdl_mem[2] = 8'h00; mdl_mem[3] = 8'h04;
        gold[0] = 8'h8C; gold[1] = 8'h01; gold[2] = 8'h00; gold[3] = 8'h04;
        do_req(1'b0, 1'b0, 32'h0, 32'h0, 10, "word_rd", rd);
        chk("word_rd const", rd, 32'h8C010004);

        // Byte read at 5 with junk in the upper bytes.
        mdl_mem[5] = 8'hA7; gold[5] = 8'hA7; mdl_junk = 24'hDEADBE;
        do_req(1'b0, 1'b1, 32'h5, 32'h0, 4, "byte_rd", rd);
        chk("byte_rd const", rd, 32'h000000A7);

        // Word write then read back; write leaves rdata unchanged.
        do_req(1'b1, 1'b0, 32'h10, 32'h12345678, 6, "word_wr", rd);
        chk("word_wr rdata_kept", rd, 32'h000000A7);
        chk("word_wr bytes", {mdl_mem[16], mdl_mem[17], mdl_mem[18], mdl_mem[19]}, 32'h12345678);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 5, "word_rd2", rd);
        chk("word_rd2 const", rd, 32'h12345678);

        // Byte write into the middle of that word.
        do_req(1'b1, 1'b1, 32'h12, 32'hFFFFFF9C, 3, "byte_wr", rd);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 3, "byte_wr_rb", rd);
        chk("byte_wr_rb const", rd, 32'h12349C78);

        // Back-to-back: req_valid held high across two reads.
        base = n_resp; mdl_busy = 4;
        e1 = gold_rd(8'h20, 1'b0); e2 = gold_rd(8'h40, 1'b0);
        req_valid = 1'b1; req_rw = 1'b0; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'd0;
        acc = 1'b0; w = 0;
        while (!acc && w < 50) begin acc = (req_ready === 1'b1); @(posedge clk); #1; w++; end
        req_addr = 32'h40;
        acc = 1'b0; w = 0; first_rd = 32'd0;
        while (!acc && w < 100) begin
            acc = (req_ready === 1'b1);
            if (resp_valid === 1'b1) first_rd = resp_rdata;
            @(posedge clk); #1; w++;
        end
        req_valid = 1'b0;
        chk("b2b resp_before_2nd", 32'(n_resp - base), 32'd1);
        chk("b2b first rdata", first_rd, e1);
        w = 0;
        while (resp_valid !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
        chk("b2b second rdata", resp_rdata, e2);
        exp_resp += 2; exp_rdata = e2;
        @(posedge clk); #1;
        chk("b2b pulses", 32'(n_resp - base), 32'd2);

        // Reset during WAIT_HI with memory busy ~20 more cycles.
        base = n_resp; mdl_busy = 26;
        req_valid = 1'b1; req_rw = 1'b0; req_byte = 1'b0; req_addr = 32'h8;
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst enable", 32'(mem_enable), 32'd0);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst addr", mem_address, 32'd0);
        ok = 1'b1; w = 0;
        while (mem_moc === 1'b0 && w < 60) begin
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) ok = 1'b0;
            @(posedge clk); #1; w++;
        end
        chk("midrst ready_low_while_busy", 32'(ok), 32'd1);
        chk("midrst moc_returned", 32'(mem_moc), 32'd1);
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        chk("midrst ready_back", 32'(req_ready), 32'd1);
        chk("midrst no_resp", 32'(n_resp - base), 32'd0);
        exp_rdata = 32'd0;

        // Memory that never drops MOC.
        mdl_hang = 1'b1;
        req_valid = 1'b1; req_rw = 1'b0; req_byte = 1'b0; req_addr = 32'h30;
        @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("tmo latency", 32'(lat), 32'(TMO));
        chk("tmo err", 32'(resp_err), 32'd1);
        chk("tmo rdata", resp_rdata, 32'd0);
        chk("tmo enable_off", 32'(mem_enable), 32'd0);
        exp_resp++; exp_rdata = 32'd0;
        @(posedge clk); #1;
        mdl_hang = 1'b0;
`else
        // Keep a different request pending to show it is ignored mid-access.
        req_addr = 32'h34;
        base = n_resp; ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (mem_address !== 32'h30) ok = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("hang no_resp", 32'(n_resp - base), 32'd0);
        chk("hang addr_stable", 32'(ok), 32'd1);
        chk("hang enable_held", 32'(mem_enable), 32'd1);
        chk("hang err", 32'(resp_err), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_hang = 1'b0;
        exp_rdata = 32'd0;
`endif

        // Random traffic.
        for (int n = 0; n < 12; n++) begin
            a = 32'($urandom_range(0, 252));
            mdl_junk = 24'($urandom);
            do_req(1'($urandom), 1'($urandom), a, $urandom, $urandom_range(3, 8), "rand", rd);
        end

        repeat (4) @(posedge clk); #1;
        chk("resp count", 32'(n_resp), 32'(exp_resp));
        chk("no consecutive resp", 32'(n_consec), 32'd0);
        chk("enable gap", 32'(gap_viol), 32'd0);
        chk("mem_* stable", 32'(mdl_unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
